fifo_drain_ctrl: RTL and testbench

Read-side controller for the data FIFO. It watches the FIFO status flags and issues `read_enable` pulses. It captures the FIFO's registered read data into a 3-entry output buffer and presents the words downstream on a valid/ready handshake. It sits between a FIFO's read port and the next pipeline stage, and is the only agent that drives that FIFO's `read_enable`.

---
 rtl/fifo_drain_ctrl_pkg.sv | 15 +
 rtl/drain_out_buffer.sv | 49 ++++
 rtl/fifo_drain_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_drain_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO drain controller: FSM state encoding,
// output buffer depth and default data width.
package fifo_drain_ctrl_pkg;

    localparam int unsigned BUF_DEPTH            = 3;
    localparam int unsigned TAMANO_DATOS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSED = 2'd2,
        ERROR  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/drain_out_buffer.sv
// Circular output buffer for fifo_drain_ctrl: push at tail, pop at head,
// occupancy count; pointers wrap at the last entry.
module drain_out_buffer
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = TAMANO_DATOS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    localparam logic [1:0] LAST = 2'(BUF_DEPTH - 1);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]       head;
    logic [1:0]       tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= (tail == LAST) ? 2'd0 : tail + 2'd1;
            end
            if (pop) begin
                head <= (head == LAST) ? 2'd0 : head + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for the data FIFO: issues read_enable, captures read
// data into a 3-entry buffer, and presents it on valid/ready.
// Optional delivered-word counter enabled by `FIFO_DRAIN_COUNT_EN.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned TAMANO_DATOS = TAMANO_DATOS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    pause,
    input  logic                    fifo_empty,
    input  logic                    fifo_error,
    input  logic [TAMANO_DATOS-1:0] fifo_data_out,
    output logic                    read_enable,
    output logic                    out_valid,
    output logic [TAMANO_DATOS-1:0] out_data,
    input  logic                    out_ready,
    output logic                    idle,
`ifdef FIFO_DRAIN_COUNT_EN
    output logic [15:0]             word_count,
`endif
    output logic                    error_out
);

    localparam logic [1:0] RES_MAX = 2'(BUF_DEPTH);

    drain_state_t state;
    drain_state_t state_nxt;
    logic [1:0]   reserved;
    logic         inflight;
    logic [1:0]   buf_count;
    logic         buf_live;
    logic         push;
    logic         pop;

    // ERROR freezes the buffer: nothing is captured or presented.
    assign buf_live    = (state != ERROR);
    assign read_enable = (state == ACTIVE) && !fifo_empty && (reserved < RES_MAX);
    assign out_valid   = buf_live && (buf_count != 2'd0);
    assign pop         = out_valid && out_ready;
    assign push        = inflight && buf_live;
    assign idle        = (state == IDLE) && (reserved == 2'd0) && !inflight;
    assign error_out   = (state == ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            reserved <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            reserved <= reserved + {1'b0, read_enable} - {1'b0, pop};
            inflight <= read_enable;
        end
    end

    always_comb begin
        state_nxt = state;
        if (fifo_error) begin
            state_nxt = ERROR;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !pause && !fifo_empty) state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    if (pause || !enable)                     state_nxt = PAUSED;
                    else if (fifo_empty && reserved == 2'd0)  state_nxt = IDLE;
                end
                PAUSED: begin
                    if (enable && !pause)
                        state_nxt = (fifo_empty && reserved == 2'd0) ? IDLE : ACTIVE;
                end
                default: state_nxt = ERROR;
            endcase
        end
    end

    drain_out_buffer #(
        .WIDTH (TAMANO_DATOS)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head_data (out_data),
        .count     (buf_count)
    );

`ifdef FIFO_DRAIN_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed self-checking bench for fifo_drain_ctrl with a small FIFO model.
module tb_fifo_drain_ctrl;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         pause;
    logic         fifo_empty;
    logic         fifo_error;
    logic [W-1:0] fifo_data_out = '0;
    logic         read_enable;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         idle;
    logic         error_out;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [15:0]  word_count;
`endif

    always #5 clk = ~clk;

    fifo_drain_ctrl #(
        .TAMANO_DATOS (W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pause         (pause),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .fifo_data_out (fifo_data_out),
        .read_enable   (read_enable),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .idle          (idle),
`ifdef FIFO_DRAIN_COUNT_EN
        .word_count    (word_count),
`endif
        .error_out     (error_out)
    );

    // FIFO model: registered read data, empty flag from pointers
    logic [W-1:0] mem [128];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         flush  = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (read_enable && rd_ptr != wr_ptr) begin
            fifo_data_out <= mem[rd_ptr % 128];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           re_count   = 0;
    int           pop_total  = 0;
    int           err_leak   = 0;
    int           ovf_events = 0;
    int           bad_re     = 0;
    logic         log_en     = 1'b1;
    logic [W-1:0] got[$];
    int           got_cyc[$];
    int           re_cyc[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (read_enable) begin
                re_count++;
                re_cyc.push_back(cyc);
                if (fifo_empty) bad_re++;
            end
            if (out_valid && out_ready) begin
                pop_total++;
                if (log_en) begin
                    got.push_back(out_data);
                    got_cyc.push_back(cyc);
                end
            end
            if (error_out && (read_enable || out_valid)) err_leak++;
            if (u_dut.u_buf.push && !u_dut.u_buf.pop && u_dut.u_buf.count == 2'd3) ovf_events++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    int re_base;
    int got_base;
    int rc_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        re_base  = re_count;
        got_base = got.size();
        rc_base  = re_cyc.size();
    endtask

    task automatic do_reset();
        enable = 1'b0;
        pause  = 1'b0;
        fifo_error = 1'b0;
        reset  = 1'b1;
        flush  = 1'b1;
        tick();
        tick();
        flush  = 1'b0;
        reset  = 1'b0;
        tick();
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 128] = W'(first + i);
            wr_ptr++;
        end
    endtask

    function automatic int got_at(input int i);
        return (got_base + i < got.size()) ? int'(got[got_base + i]) : -1;
    endfunction

    task automatic wait_got(input int n, input int limit);
        for (int i = 0; i < limit && (got.size() - got_base) < n; i++) tick();
    endtask

    task automatic wait_re(input int n, input int limit);
        for (int i = 0; i < limit && (re_count - re_base) < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && !idle; i++) tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        reset = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable     = 1'($urandom);
            pause      = 1'($urandom);
            fifo_error = 1'($urandom);
            out_ready  = 1'($urandom);
            tick();
        end
        @(negedge clk);
        check("rst_read_enable", 32'(read_enable), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_error_out", 32'(error_out), 0);
`ifdef FIFO_DRAIN_COUNT_EN
        check("rst_word_count", 32'(word_count), 0);
`endif

        // Streaming: 8 words at full rate
        do_reset();
        out_ready = 1'b1;
        load(1, 8);
        snap();
        enable = 1'b1;
        wait_got(8, 40);
        wait_idle(20);
        check("stream_re_count", re_count - re_base, 8);
        check("stream_got_count", got.size() - got_base, 8);
        for (int i = 0; i < 8; i++) check("stream_data", got_at(i), i + 1);
        if (re_cyc.size() >= rc_base + 8 && got_cyc.size() >= got_base + 8) begin
            check("stream_latency", got_cyc[got_base] - re_cyc[rc_base], 2);
            for (int i = 1; i < 8; i++) begin
                check("stream_re_back2back", re_cyc[rc_base + i] - re_cyc[rc_base], i);
                check("stream_out_back2back", got_cyc[got_base + i] - got_cyc[got_base], i);
            end
        end
        check("stream_idle", 32'(idle), 1);

        // Backpressure: only 3 slots may be claimed
        do_reset();
        out_ready = 1'b0;
        load(1, 5);
        snap();
        enable = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        check("bp_re_count", re_count - re_base, 3);
        check("bp_reserved", 32'(u_dut.reserved), 3);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_out_data", 32'(out_data), 1);
        repeat (3) tick();
        @(negedge clk);
        check("bp_hold", 32'(out_data), 1);
        tick();
        out_ready = 1'b1;
        wait_got(5, 40);
        check("bp_re_total", re_count - re_base, 5);
        check("bp_got_count", got.size() - got_base, 5);
        for (int i = 0; i < 5; i++) check("bp_data", got_at(i), i + 1);

        // Pause after two reads; in-flight words still drain
        do_reset();
        out_ready = 1'b1;
        load(1, 6);
        snap();
        enable = 1'b1;
        wait_re(2, 20);
        pause = 1'b1;
        repeat (10) tick();
        check("pause_re_count", re_count - re_base, 2);
        check("pause_got_count", got.size() - got_base, 2);
        check("pause_data0", got_at(0), 1);
        check("pause_data1", got_at(1), 2);
        pause = 1'b0;
        wait_got(6, 40);
        check("resume_re_count", re_count - re_base, 6);
        for (int i = 2; i < 6; i++) check("resume_data", got_at(i), i + 1);

        // Error mid-stream is sticky until reset
        do_reset();
        out_ready = 1'b1;
        load(1, 8);
        snap();
        rc_base = err_leak;
        enable = 1'b1;
        wait_re(3, 20);
        fifo_error = 1'b1;
        tick();
        fifo_error = 1'b0;
        @(negedge clk);
        check("err_error_out", 32'(error_out), 1);
        check("err_read_enable", 32'(read_enable), 0);
        check("err_out_valid", 32'(out_valid), 0);
        repeat (10) tick();
        @(negedge clk);
        check("err_sticky", 32'(error_out), 1);
        check("err_leak", err_leak - rc_base, 0);
        check("err_re_count", re_count - re_base, 3);
        do_reset();
        @(negedge clk);
        check("err_cleared", 32'(error_out), 0);
        check("err_idle_after_reset", 32'(idle), 1);

        // Long stream: 70000 words
        do_reset();
        log_en = 1'b0;
        out_ready = 1'b1;
        rc_base = pop_total;
        wr_ptr = wr_ptr + 70000;
        enable = 1'b1;
        for (int i = 0; i < 70100 && (pop_total - rc_base) < 70000; i++) tick();
        wait_idle(20);
        check("long_pop_count", pop_total - rc_base, 70000);
        check("long_idle", 32'(idle), 1);
`ifdef FIFO_DRAIN_COUNT_EN
        check("long_word_count", 32'(word_count), 4464);
`endif

        check("no_read_when_empty", bad_re, 0);
        check("no_buffer_overflow", ovf_events, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
